// File: rtl/tr_seq_pkg.sv
// tr_seq_pkg: sequencer state encoding and stage_dly field-select macro
`ifndef TR_SEQ_DLY
`define TR_SEQ_DLY(v, k, w) v[(k)*(w) +: (w)]
`endif
package tr_seq_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    TX      = 3'd2,
    DOWN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;
endpackage

// File: rtl/tr_seq_timer.sv
// tr_seq_timer: loadable down-counter (clk, rst, load/val, dec) with zero flag
module tr_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/tr_sequencer.sv
// tr_sequencer: ordered T/R stage ramp-up/down around ptt_req with TX watchdog and lockout
module tr_sequencer
  import tr_seq_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int CNTW   = 16,
  parameter int TOW    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ptt_req,
  input  logic                   tx_inhibit,
  input  logic [NSTAGE*CNTW-1:0] stage_dly,
  input  logic [TOW-1:0]         timeout_cycles,
  output logic [NSTAGE-1:0]      stage_en,
  output logic                   tx_grant,
  output logic                   busy,
  output logic                   timeout_flag
);
  localparam int IW = NSTAGE > 1 ? $clog2(NSTAGE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSTAGE - 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, ld_idx;
  logic [NSTAGE-1:0] en_n;
  logic [TOW-1:0] wd, wd_n;
  logic [CNTW-1:0] ld_val;
  logic grant_n, pend, pend_n, ld, dec, zero, abort, wd_fire;
  assign ld_val = `TR_SEQ_DLY(stage_dly, int'(ld_idx), CNTW);
  assign abort = !ptt_req || tx_inhibit;
  assign wd_fire = tx_grant && timeout_cycles != '0 && wd == timeout_cycles - TOW'(1);
  assign busy = state != IDLE;
  assign timeout_flag = state == LOCKOUT;
  tr_seq_timer #(.W(CNTW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .dec  (dec),
    .val  (ld_val),
    .zero (zero)
  );
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ld_idx  = idx;
    ld      = 1'b0;
    dec     = 1'b0;
    en_n    = stage_en;
    grant_n = 1'b0;
    wd_n    = wd;
    pend_n  = pend;
    case (state)
      IDLE: if (!abort) begin
        state_n = UP;
        idx_n   = '0;
        ld_idx  = '0;
        ld      = 1'b1;
      end
      UP: if (abort) begin
        // stages below idx are all set, so idx-1 is the highest asserted one
        state_n = idx == '0 ? IDLE : DOWN;
        idx_n   = idx - IW'(1);
        ld_idx  = idx - IW'(1);
        ld      = idx != '0;
      end else if (!zero) dec = 1'b1;
      else begin
        en_n[idx] = 1'b1;
        if (idx == LAST) begin
          state_n = TX;
          wd_n    = '0;
        end else begin
          idx_n  = idx + IW'(1);
          ld_idx = idx + IW'(1);
          ld     = 1'b1;
        end
      end
      TX: if (abort || wd_fire) begin
        state_n = DOWN;
        idx_n   = LAST;
        ld_idx  = LAST;
        ld      = 1'b1;
        pend_n  = wd_fire;
      end else begin
        grant_n = 1'b1;
        // counting only while granted makes the grant last exactly timeout_cycles
        wd_n    = tx_grant && wd != '1 ? wd + TOW'(1) : wd;
      end
      DOWN: if (!zero) dec = 1'b1;
      else begin
        en_n[idx] = 1'b0;
        if (idx == '0) state_n = pend ? LOCKOUT : IDLE;
        else begin
          idx_n  = idx - IW'(1);
          ld_idx = idx - IW'(1);
          ld     = 1'b1;
        end
      end
      LOCKOUT: if (!ptt_req) begin
        state_n = IDLE;
        pend_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      stage_en <= '0;
      tx_grant <= 1'b0;
      wd       <= '0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      stage_en <= en_n;
      tx_grant <= grant_n;
      wd       <= wd_n;
      pend     <= pend_n;
    end
endmodule

// File: tb/tb_tr_sequencer.sv
// tb_tr_sequencer: directed timing checks of tr_sequencer ramp, abort, watchdog, inhibit and reset
module tb_tr_sequencer;
  logic clk = 0, rst = 1, ptt_req = 0, tx_inhibit = 0;
  logic [47:0] stage_dly = {16'd1, 16'd3, 16'd2};
  logic [23:0] timeout_cycles = '0;
  logic [2:0] stage_en;
  logic tx_grant, busy, timeout_flag;
  int total = 0, bad = 0;
  tr_sequencer #(.NSTAGE(3), .CNTW(16), .TOW(24)) dut (
    .clk            (clk),
    .rst            (rst),
    .ptt_req        (ptt_req),
    .tx_inhibit     (tx_inhibit),
    .stage_dly      (stage_dly),
    .timeout_cycles (timeout_cycles),
    .stage_en       (stage_en),
    .tx_grant       (tx_grant),
    .busy           (busy),
    .timeout_flag   (timeout_flag)
  );
  always #5 clk = ~clk;
  task step();
    @(posedge clk);
    #1;
  endtask
  task test_reset();
    rst = 1;
    step();
    step();
    total += 4;
    if (stage_en !== 3'b000) begin bad++; $display("FAIL reset stage_en got=%b want=000", stage_en); end
    if (tx_grant !== 1'b0) begin bad++; $display("FAIL reset tx_grant got=%b want=0", tx_grant); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset timeout_flag got=%b want=0", timeout_flag); end
    rst = 0;
    step();
  endtask
  task test_keyup_release();
    logic [2:0] e;
    ptt_req = 1;
    for (int j = 0; j <= 12; j++) begin
      step();
      e = {j >= 9, j >= 7, j >= 3};
      total += 3;
      if (stage_en !== e) begin bad++; $display("FAIL keyup stage_en N+%0d got=%b want=%b", j, stage_en, e); end
      if (tx_grant !== (j >= 10)) begin bad++; $display("FAIL keyup tx_grant N+%0d got=%b want=%b", j, tx_grant, j >= 10); end
      if (busy !== 1'b1) begin bad++; $display("FAIL keyup busy N+%0d got=%b want=1", j, busy); end
    end
    ptt_req = 0;
    for (int k = 0; k <= 11; k++) begin
      step();
      e = {k < 2, k < 6, k < 9};
      total += 3;
      if (stage_en !== e) begin bad++; $display("FAIL release stage_en M+%0d got=%b want=%b", k, stage_en, e); end
      if (tx_grant !== 1'b0) begin bad++; $display("FAIL release tx_grant M+%0d got=%b want=0", k, tx_grant); end
      if (busy !== (k < 9)) begin bad++; $display("FAIL release busy M+%0d got=%b want=%b", k, busy, k < 9); end
    end
  endtask
  task test_abort();
    logic [2:0] e;
    ptt_req = 1;
    for (int j = 0; j <= 11; j++) begin
      step();
      if (j == 4) ptt_req = 0;
      e = {2'b00, j >= 3 && j < 8};
      total += 3;
      if (stage_en !== e) begin bad++; $display("FAIL abort stage_en N+%0d got=%b want=%b", j, stage_en, e); end
      if (tx_grant !== 1'b0) begin bad++; $display("FAIL abort tx_grant N+%0d got=%b want=0", j, tx_grant); end
      if (busy !== (j < 8)) begin bad++; $display("FAIL abort busy N+%0d got=%b want=%b", j, busy, j < 8); end
    end
  endtask
  task test_watchdog();
    logic [2:0] e;
    timeout_cycles = 24'd20;
    ptt_req = 1;
    for (int j = 0; j <= 45; j++) begin
      step();
      e = {j >= 9 && j < 32, j >= 7 && j < 36, j >= 3 && j < 39};
      total += 3;
      if (stage_en !== e) begin bad++; $display("FAIL wdog stage_en N+%0d got=%b want=%b", j, stage_en, e); end
      if (tx_grant !== (j >= 10 && j < 30)) begin bad++; $display("FAIL wdog tx_grant N+%0d got=%b want=%b", j, tx_grant, j >= 10 && j < 30); end
      if (busy !== 1'b1) begin bad++; $display("FAIL wdog busy N+%0d got=%b want=1", j, busy); end
      if (j >= 39) begin
        total++;
        if (timeout_flag !== 1'b1) begin bad++; $display("FAIL wdog timeout_flag N+%0d got=%b want=1", j, timeout_flag); end
      end
    end
    ptt_req = 0;
    step();
    total += 2;
    if (timeout_flag !== 1'b0) begin bad++; $display("FAIL lockout_exit timeout_flag got=%b want=0", timeout_flag); end
    if (busy !== 1'b0) begin bad++; $display("FAIL lockout_exit busy got=%b want=0", busy); end
    timeout_cycles = '0;
    step();
  endtask
  task test_inhibit();
    logic [2:0] e;
    tx_inhibit = 1;
    ptt_req = 1;
    for (int j = 0; j < 3; j++) begin
      step();
      total += 3;
      if (stage_en !== 3'b000) begin bad++; $display("FAIL inhibit_idle stage_en got=%b want=000", stage_en); end
      if (tx_grant !== 1'b0) begin bad++; $display("FAIL inhibit_idle tx_grant got=%b want=0", tx_grant); end
      if (busy !== 1'b0) begin bad++; $display("FAIL inhibit_idle busy got=%b want=0", busy); end
    end
    tx_inhibit = 0;
    for (int j = 0; j <= 12; j++) step();
    total++;
    if (tx_grant !== 1'b1) begin bad++; $display("FAIL inhibit_keyup tx_grant got=%b want=1", tx_grant); end
    tx_inhibit = 1;
    for (int k = 0; k <= 11; k++) begin
      step();
      e = {k < 2, k < 6, k < 9};
      total += 3;
      if (stage_en !== e) begin bad++; $display("FAIL inhibit_tx stage_en M+%0d got=%b want=%b", k, stage_en, e); end
      if (tx_grant !== 1'b0) begin bad++; $display("FAIL inhibit_tx tx_grant M+%0d got=%b want=0", k, tx_grant); end
      if (busy !== (k < 9)) begin bad++; $display("FAIL inhibit_tx busy M+%0d got=%b want=%b", k, busy, k < 9); end
    end
    ptt_req = 0;
    tx_inhibit = 0;
    step();
  endtask
  task test_zero_delays();
    logic [2:0] e;
    stage_dly = '0;
    ptt_req = 1;
    for (int j = 0; j <= 5; j++) begin
      step();
      e = {j >= 3, j >= 2, j >= 1};
      total += 2;
      if (stage_en !== e) begin bad++; $display("FAIL zero_dly stage_en N+%0d got=%b want=%b", j, stage_en, e); end
      if (tx_grant !== (j >= 4)) begin bad++; $display("FAIL zero_dly tx_grant N+%0d got=%b want=%b", j, tx_grant, j >= 4); end
    end
  endtask
  task test_reset_in_tx();
    rst = 1;
    step();
    total += 3;
    if (stage_en !== 3'b000) begin bad++; $display("FAIL rst_tx stage_en got=%b want=000", stage_en); end
    if (tx_grant !== 1'b0) begin bad++; $display("FAIL rst_tx tx_grant got=%b want=0", tx_grant); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_tx busy got=%b want=0", busy); end
    rst = 0;
    ptt_req = 0;
    step();
  endtask
  task test_rekey_in_down();
    logic [2:0] e;
    ptt_req = 1;
    for (int j = 0; j <= 5; j++) step();
    ptt_req = 0;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 1) ptt_req = 1;
      e = {k < 1, k < 2, k < 3 || k >= 5};
      total += 2;
      if (stage_en !== e) begin bad++; $display("FAIL rekey stage_en M+%0d got=%b want=%b", k, stage_en, e); end
      if (busy !== (k != 3)) begin bad++; $display("FAIL rekey busy M+%0d got=%b want=%b", k, busy, k != 3); end
    end
    ptt_req = 0;
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_keyup_release();
    test_abort();
    test_watchdog();
    test_inhibit();
    test_zero_delays();
    test_reset_in_tx();
    test_rekey_in_down();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
